// File: rtl/reg_mult_sequencer.sv
// Register-file handshake sequencer: reads Rs/Rm, computes Rs*Rm^N mod 2^DATA_W, writes rd.
// Latency 9+32N cycles with a zero-wait responder; each req is held stable until ack arrives.
module reg_mult_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rm_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  iter_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              req,
  input  logic              ack,
  output logic              read_enable,
  output logic [ADDR_W-1:0] in_address1,
  output logic [ADDR_W-1:0] in_address2,
  input  logic [DATA_W-1:0] out_data1,
  input  logic [DATA_W-1:0] out_data2,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_REL, MUL, WR_REQ, WR_REL, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] m;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] mcand;
  logic [CNT_W-1:0]  iter;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] prod_nxt;

  // acc doubles as the multiplier shift register; it is reloaded with the product at the end
  assign prod_nxt = prod + (acc[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      req           <= 1'b0;
      read_enable   <= 1'b0;
      write_enable  <= 1'b0;
      in_address1   <= '0;
      in_address2   <= '0;
      write_address <= '0;
      write_data    <= '0;
      acc           <= '0;
      m             <= '0;
      prod          <= '0;
      mcand         <= '0;
      iter          <= '0;
      bit_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            in_address1   <= rs_addr;
            in_address2   <= rm_addr;
            write_address <= rd_addr;
            iter          <= iter_count;
            busy          <= 1'b1;
            // an abandoned handshake may leave ack high; req waits for it to clear
            req           <= ~ack;
            read_enable   <= ~ack;
            state         <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (req && ack) begin
            acc         <= out_data1;
            m           <= out_data2;
            req         <= 1'b0;
            read_enable <= 1'b0;
            state       <= RD_REL;
          end else if (!req && !ack) begin
            req         <= 1'b1;
            read_enable <= 1'b1;
          end
        end
        RD_REL: begin
          if (!ack) begin
            if (iter != '0) begin
              prod    <= '0;
              mcand   <= m;
              bit_cnt <= '0;
              state   <= MUL;
            end else begin
              req          <= 1'b1;
              write_enable <= 1'b1;
              write_data   <= acc;
              state        <= WR_REQ;
            end
          end
        end
        MUL: begin
          prod    <= prod_nxt;
          mcand   <= mcand << 1;
          acc     <= acc >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            acc     <= prod_nxt;
            prod    <= '0;
            mcand   <= m;
            bit_cnt <= '0;
            iter    <= iter - 1'b1;
            if (iter == CNT_W'(1)) begin
              req          <= ~ack;
              write_enable <= ~ack;
              write_data   <= prod_nxt;
              state        <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (req && ack) begin
            req          <= 1'b0;
            write_enable <= 1'b0;
            state        <= WR_REL;
          end else if (!req && !ack) begin
            req          <= 1'b1;
            write_enable <= 1'b1;
          end
        end
        WR_REL: begin
          if (!ack) begin
            done   <= 1'b1;
            result <= acc;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_mult_sequencer.sv
// Bench for reg_mult_sequencer: register-file responder model plus Rs*Rm^N reference.
module tb_reg_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  rs_addr = '0, rm_addr = '0, rd_addr = '0;
  logic [3:0]  iter_count = '0;
  logic        busy, done, req, read_enable, write_enable;
  logic [31:0] result, write_data;
  logic        ack = 1'b0;
  logic [3:0]  in_address1, in_address2, write_address;
  logic [31:0] out_data1 = '0, out_data2 = '0;

  reg_mult_sequencer #(.DATA_W(32), .ADDR_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rs_addr(rs_addr), .rm_addr(rm_addr), .rd_addr(rd_addr), .iter_count(iter_count),
    .busy(busy), .done(done), .result(result),
    .req(req), .ack(ack), .read_enable(read_enable),
    .in_address1(in_address1), .in_address2(in_address2),
    .out_data1(out_data1), .out_data2(out_data2),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] ref_mult(input logic [31:0] s, input logic [31:0] mul, input int n);
    logic [31:0] a;
    a = s;
    for (int i = 0; i < n; i++) a = a * mul;
    return a;
  endfunction

  // Register file responder: ack rises delay+1 cycles after req, drops one cycle after req falls.
  logic [31:0] model_regs [16];
  int          rd_delay = 0, wr_delay = 0;
  int          hi_cnt = 0, lo_cnt = 0;
  int          wr_cnt = 0, unstable = 0, rise_viol = 0;
  logic [3:0]  last_wr_addr = '0;
  logic [45:0] snap = '0;

  always @(negedge clk) begin
    if (req) begin hi_cnt++; lo_cnt = 0; end
    else begin lo_cnt++; hi_cnt = 0; end
    if (req && hi_cnt == 1) begin
      snap = {read_enable, write_enable, in_address1, in_address2, write_address, write_data};
      if (ack) rise_viol++;
    end else if (req && snap != {read_enable, write_enable, in_address1, in_address2, write_address, write_data})
      unstable++;
    if (!ack && req && hi_cnt >= (write_enable ? wr_delay : rd_delay) + 2) begin
      ack = 1'b1;
      if (write_enable) begin
        model_regs[write_address] = write_data;
        last_wr_addr = write_address;
        wr_cnt++;
      end else begin
        out_data1 = model_regs[in_address1];
        out_data2 = model_regs[in_address2];
      end
    end else if (ack && lo_cnt >= 2) begin
      ack = 1'b0;
    end
  end

  // Latency counts edges from the edge that samples start to the edge that first sees done.
  task automatic run_op(input int rs, input int rm, input int rd, input int n,
                        input int rdl, input int wdl, input int poke_at, input int abort_at);
    logic [31:0] exp_val, old_rd;
    int lat, wc0;
    bit seen, aborted;
    exp_val = ref_mult(model_regs[rs], model_regs[rm], n);
    old_rd = model_regs[rd];
    rd_delay = rdl; wr_delay = wdl;
    unstable = 0; rise_viol = 0; wc0 = wr_cnt;
    @(negedge clk);
    start = 1'b1; rs_addr = 4'(rs); rm_addr = 4'(rm); rd_addr = 4'(rd); iter_count = 4'(n);
    lat = 0; seen = 0; aborted = 0;
    while (!seen && !aborted && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (poke_at > 0 && lat == poke_at) begin
        start = 1'b1; rs_addr = 4'(rm); rm_addr = 4'(rs); rd_addr = 4'(rd ^ 1); iter_count = 4'(n + 1);
      end
      if (poke_at > 0 && lat == poke_at + 1) start = 1'b0;
      if (abort_at > 0 && lat == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_req", req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_we", write_enable, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_write", wr_cnt - wc0, 0);
        chk("abort_rd_kept", model_regs[rd], old_rd);
        aborted = 1;
      end
      if (done) seen = 1;
    end
    if (!aborted) begin
      chk("done_seen", seen, 1);
      chk("latency", lat, 9 + 32 * n + rdl + wdl);
      chk("busy_at_done", busy, 1);
      chk("result", result, exp_val);
      chk("rd_value", model_regs[rd], exp_val);
      chk("write_count", wr_cnt - wc0, 1);
      chk("write_addr", last_wr_addr, rd);
      chk("held_stable", unstable, 0);
      chk("req_rise_ack_low", rise_viol, 0);
      @(negedge clk);
      chk("done_one_pulse", done, 0);
      chk("busy_after_done", busy, 0);
      chk("result_held", result, exp_val);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model_regs[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re_we", {read_enable, write_enable}, 0);
    chk("rst_result", result, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_addr", {in_address1, in_address2, write_address}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    model_regs[0] = 32'd2; model_regs[1] = 32'd2;
    run_op(0, 1, 2, 10, 0, 0, 0, 0);
    chk("pow2_r2", model_regs[2], 32'h0000_0800);

    model_regs[3] = 32'h0001_0000; model_regs[4] = 32'h0001_0000;
    run_op(3, 4, 2, 1, 0, 0, 0, 0);
    chk("wrap_r2", model_regs[2], 32'h0000_0000);

    model_regs[5] = 32'hFFFF_FFFF; model_regs[6] = 32'd3;
    run_op(5, 6, 7, 1, 0, 0, 0, 0);
    chk("ffff_x3_r7", model_regs[7], 32'hFFFF_FFFD);

    model_regs[8] = 32'h1234_5678;
    run_op(8, 1, 9, 0, 0, 0, 0, 0);
    chk("copy_r9", model_regs[9], 32'h1234_5678);

    run_op(0, 1, 10, 10, 5, 5, 0, 0);
    chk("slow_ack_r10", model_regs[10], 32'h0000_0800);

    run_op(0, 1, 11, 3, 0, 0, 40, 0);
    chk("poke_r11", model_regs[11], 32'd16);

    run_op(0, 1, 13, 2, 0, 0, 0, 20);
    run_op(0, 1, 13, 2, 0, 0, 0, 0);
    chk("after_mul_abort_r13", model_regs[13], 32'd8);

    run_op(0, 1, 14, 1, 0, 5, 0, 39);
    run_op(0, 1, 14, 1, 0, 0, 0, 0);
    chk("after_wr_abort_r14", model_regs[14], 32'd4);

    for (int t = 0; t < 20; t++) begin
      run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_mult_sequencer.md
# reg_mult_sequencer

Handshake initiator that drives the register file's req/ack port on behalf of the multiply datapath. On `start` it reads two source registers, repeatedly multiplies an accumulator by the second operand with a bit-serial shift-add engine, and writes the 32-bit result back to a destination register. It replaces hand-sequenced read/multiply/write stimulus with a self-timed controller sitting between instruction issue and `register_file`.

## Interface

Parameters:
- `DATA_W`, 32, operand/result width
- `ADDR_W`, 4, register address width
- `CNT_W`, 4, iteration-count width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin operation; sampled only in IDLE
- `rs_addr`  in  ADDR_W  source register for accumulator seed (Rs)
- `rm_addr`  in  ADDR_W  source register for multiplier (Rm)
- `rd_addr`  in  ADDR_W  destination register
- `iter_count`  in  CNT_W  number of multiplies N
- `busy`  out  1  high from start accept until DONE exits
- `done`  out  1  one-cycle pulse when write-back handshake completes
- `result`  out  DATA_W  final accumulator, held until next accepted start
- `req`  out  1  request to register file
- `ack`  in  1  acknowledge from register file
- `read_enable`  out  1  read strobe, valid with req in read phase
- `in_address1`, `in_address2`  out  ADDR_W  read addresses (rs, rm)
- `out_data1`, `out_data2`  in  DATA_W  read data, valid while ack high
- `write_enable`  out  1  write strobe, valid with req in write phase
- `write_address`  out  ADDR_W  write address (rd)
- `write_data`  out  DATA_W  write data

## Operation

- States: IDLE, RD_REQ, RD_REL, MUL, WR_REQ, WR_REL, DONE.
- IDLE: `start`=1 latches rs/rm/rd addresses and N; -> RD_REQ. `start` in any other state is ignored.
- RD_REQ: `req`=1, `read_enable`=1, addresses driven. On `ack`=1: capture acc<=out_data1, m<=out_data2; -> RD_REL.
- RD_REL: `req`=0, `read_enable`=0; wait `ack`=0 (4-phase return-to-zero). Then -> MUL if N>0, else WR_REQ.
- MUL: per iteration, 32 shift-add cycles compute acc*m; acc takes the low DATA_W bits of the product (overflow bits discarded, unsigned). Iteration counter decrements; after N iterations -> WR_REQ.
- WR_REQ: `req`=1, `write_enable`=1, `write_address`=rd, `write_data`=acc. On `ack`=1 -> WR_REL.
- WR_REL: `req`=0, `write_enable`=0; wait `ack`=0 -> DONE.
- DONE: `done`=1 for one cycle, `result`=acc; -> IDLE.
- Result = Rs * Rm^N mod 2^32. N=0 copies Rs to rd.
- `ack` high while in IDLE, MUL, or DONE is ignored; `req` never rises while `ack` is still high.
- Reset (any state, async): state IDLE; `req`, `read_enable`, `write_enable`, `busy`, `done` = 0; `result`, `write_data`, addresses, acc = 0. An in-flight handshake is abandoned, and the next read waits for `ack` low first.

## Timing

- `start` sampled at edge T0; `req` high from T0+1.
- `ack` sampled each edge; capture/transition on the first edge with `ack`=1. Arbitrarily long ack delay is tolerated, with `req` held stable.
- `req` drops on the edge after `ack` is seen.
- MUL: exactly 32*N cycles.
- With a zero-wait responder (ack one cycle after req, drop one cycle after req falls), total latency from start to `done` = 1 + 2 + 2 + 32N + 2 + 2 cycles. `busy` falls on the cycle after `done`.
- All outputs registered.

## Test plan

- Rs=r0=2, Rm=r1=2, N=10, rd=r2, immediate ack -> r2=0x00000800, `done` pulse once, latency 9+320 cycles.
- Rs=0x00010000, Rm=0x00010000, N=1 -> r2=0x00000000 (wrap). Rs=0xFFFFFFFF, Rm=3, N=1 -> 0xFFFFFFFD.
- N=0, Rs=0x12345678 -> rd=0x12345678 with no MUL cycles; latency 9.
- Ack delayed 5 cycles in RD_REQ and WR_REQ -> `req` and the addresses/data are held stable throughout; result is unchanged; latency +10.
- `start` pulsed during MUL with different addresses -> ignored, and the original operation completes with the original rd.
- `rst_n` low mid-MUL (and separately mid-WR_REQ) -> `req`/`busy`/`write_enable` are 0 immediately, no write occurs, and a subsequent start completes correctly.
